// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: byte FIFO feeding a start/data/parity/stop serialiser
// with a programmable bit period. Frame format is captured when a byte is popped.
module uart_tx_fifo #(
    parameter int log2_fifosz = 4
) (
    input  logic                 i_clk,
    input  logic                 i_nrst,
    input  logic                 i_enable,
    input  logic [15:0]          i_scaler,
    input  logic                 i_parity_en,
    input  logic                 i_parity_odd,
    input  logic                 i_stop2,
    input  logic [7:0]           i_wdata,
    input  logic                 i_wvalid,
    output logic                 o_wready,
    output logic [log2_fifosz:0] o_fifo_cnt,
    output logic                 o_empty,
    output logic                 o_busy,
    output logic                 o_tx
);

    localparam int unsigned DEPTH = 2 ** log2_fifosz;
    localparam logic [log2_fifosz:0] FULL_CNT = {1'b1, {log2_fifosz{1'b0}}};

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP1  = 3'd4;
    localparam logic [2:0] ST_STOP2  = 3'd5;

    logic [7:0]             mem_q [DEPTH];
    logic [log2_fifosz-1:0] wr_ptr_q, wr_ptr_d;
    logic [log2_fifosz-1:0] rd_ptr_q, rd_ptr_d;
    logic [log2_fifosz:0]   cnt_q, cnt_d;
    logic [2:0]             state_q, state_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [15:0]            scl_cnt_q, scl_cnt_d;
    logic [15:0]            scl_q, scl_d;
    logic [7:0]             shreg_q, shreg_d;
    logic                   par_bit_q, par_bit_d;
    logic                   par_en_q, par_en_d;
    logic                   stop2_q, stop2_d;
    logic                   tx_q, tx_d;

    logic       push;
    logic       pop;
    logic       bit_end;
    logic       frame_done;
    logic       load;
    logic [7:0] head;

    assign head     = mem_q[rd_ptr_q];
    assign push     = i_wvalid && (cnt_q != FULL_CNT);
    assign bit_end  = (scl_cnt_q == scl_q);

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        scl_cnt_d  = scl_cnt_q;
        scl_d      = scl_q;
        shreg_d    = shreg_q;
        par_bit_d  = par_bit_q;
        par_en_d   = par_en_q;
        stop2_d    = stop2_q;
        frame_done = 1'b0;
        load       = 1'b0;

        if (state_q != ST_IDLE) begin
            scl_cnt_d = bit_end ? 16'd0 : scl_cnt_q + 16'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (i_enable && (cnt_q != '0)) begin
                    load = 1'b1;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    shreg_d   = {1'b0, shreg_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = par_en_q ? ST_PARITY : ST_STOP1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_d = ST_STOP1;
                end
            end
            ST_STOP1: begin
                if (bit_end) begin
                    if (stop2_q) begin
                        state_d = ST_STOP2;
                    end else begin
                        frame_done = 1'b1;
                    end
                end
            end
            ST_STOP2: begin
                if (bit_end) begin
                    frame_done = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // End of the last stop bit chains straight into the next start bit when data is waiting.
        if (frame_done) begin
            if (i_enable && (cnt_q != '0)) begin
                load = 1'b1;
            end else begin
                state_d = ST_IDLE;
            end
        end

        if (load) begin
            state_d   = ST_START;
            shreg_d   = head;
            par_bit_d = (^head) ^ i_parity_odd;
            par_en_d  = i_parity_en;
            stop2_d   = i_stop2;
            scl_d     = i_scaler;
            scl_cnt_d = 16'd0;
            bit_cnt_d = 3'd0;
        end
        pop = load;
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Line level is registered from the current state, so it trails the FSM by one clock.
    always_comb begin
        case (state_q)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shreg_q[0];
            ST_PARITY: tx_d = par_bit_q;
            default:   tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            scl_cnt_q <= '0;
            scl_q     <= '0;
            shreg_q   <= '0;
            par_bit_q <= 1'b0;
            par_en_q  <= 1'b0;
            stop2_q   <= 1'b0;
            tx_q      <= 1'b1;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            scl_cnt_q <= scl_cnt_d;
            scl_q     <= scl_d;
            shreg_q   <= shreg_d;
            par_bit_q <= par_bit_d;
            par_en_q  <= par_en_d;
            stop2_q   <= stop2_d;
            tx_q      <= tx_d;
        end
    end

    assign o_wready   = (cnt_q != FULL_CNT);
    assign o_fifo_cnt = cnt_q;
    assign o_busy     = (state_q != ST_IDLE);
    assign o_empty    = (cnt_q == '0) && (state_q == ST_IDLE);
    assign o_tx       = tx_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: pushed bytes go to a scoreboard; a line monitor decodes
// each frame clock by clock against the configuration in force when it started.
module tb_uart_tx_fifo;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [15:0] scaler = 16'd0;
    logic        par_en = 1'b0;
    logic        par_odd = 1'b0;
    logic        stop2 = 1'b0;
    logic [7:0]  wdata = 8'h00;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [4:0]  fifo_cnt;
    logic        empty;
    logic        busy;
    logic        tx;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [7:0]  sb[$];
    int unsigned cyc = 0;
    bit          mon_busy = 1'b0;
    bit          b2b_check = 1'b0;
    bit          b2b_seen = 1'b0;
    int unsigned last_end = 0;

    uart_tx_fifo #(.log2_fifosz(4)) dut (
        .i_clk       (clk),
        .i_nrst      (rst_n),
        .i_enable    (en),
        .i_scaler    (scaler),
        .i_parity_en (par_en),
        .i_parity_odd(par_odd),
        .i_stop2     (stop2),
        .i_wdata     (wdata),
        .i_wvalid    (wvalid),
        .o_wready    (wready),
        .o_fifo_cnt  (fifo_cnt),
        .o_empty     (empty),
        .o_busy      (busy),
        .o_tx        (tx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic exp_bit(input logic [7:0] d, input int k, input bit pe, input bit po);
        if (k == 0) return 1'b0;
        if (k <= 8) return d[k-1];
        if (k == 9 && pe) return (^d) ^ po;
        return 1'b1;
    endfunction

    task automatic push_byte(input logic [7:0] b);
        @(posedge clk);
        #1 wdata = b;
        wvalid = 1'b1;
        sb.push_back(b);
        @(posedge clk);
        #1 wvalid = 1'b0;
    endtask

    // Runs until the DUT and monitor are idle, counting clocks with o_busy high.
    task automatic run_frames(input string tag, input int exp_busy, input int pre, input int budget);
        int n;
        int i;
        n = pre;
        i = 0;
        while (!(empty && sb.size() == 0 && !mon_busy) && i < budget) begin
            @(posedge clk);
            #1;
            if (busy) n++;
            i++;
        end
        check_val({tag, "_reached_idle"}, (i < budget), 1);
        check_val({tag, "_busy_clks"}, n, exp_busy);
    endtask

    // Line monitor: one scoreboard entry per detected start bit.
    initial begin
        logic [7:0] d;
        int         s, nb, len;
        bit         pe, po;
        forever begin
            @(negedge clk);
            if (rst_n && tx == 1'b0) begin
                if (sb.size() == 0) begin
                    check_val("unexpected_start", tx, 1);
                    for (int w = 0; w < 2000 && tx == 1'b0; w++) @(negedge clk);
                end else begin
                    d  = sb.pop_front();
                    s  = int'(scaler);
                    pe = par_en;
                    po = par_odd;
                    nb = 10 + (par_en ? 1 : 0) + (stop2 ? 1 : 0);
                    len = nb * (s + 1);
                    check_val("cnt_at_start", fifo_cnt, sb.size());
                    if (b2b_check) begin
                        if (b2b_seen) check_val("no_idle_gap", cyc, last_end + 1);
                        b2b_seen = 1'b1;
                    end
                    mon_busy = 1'b1;
                    for (int k = 0; k < len; k++) begin
                        if (k > 0) @(negedge clk);
                        if (!rst_n) break;
                        check_val("tx_bit", tx, exp_bit(d, k / (s + 1), pe, po));
                        last_end = cyc;
                    end
                    mon_busy = 1'b0;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int pre;
        int w;

        repeat (3) @(posedge clk);
        #1;
        check_val("rst_tx", tx, 1);
        check_val("rst_cnt", fifo_cnt, 0);
        check_val("rst_wready", wready, 1);
        check_val("rst_empty", empty, 1);
        check_val("rst_busy", busy, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // 8N1 at 4 clocks per bit, with first-frame latency.
        scaler = 16'd3;
        en = 1'b1;
        push_byte(8'h55);
        check_val("push_cnt", fifo_cnt, 1);
        check_val("push_busy", busy, 0);
        @(posedge clk);
        #1;
        check_val("pop_busy", busy, 1);
        check_val("pop_cnt", fifo_cnt, 0);
        check_val("pop_tx_high", tx, 1);
        @(posedge clk);
        #1;
        check_val("start_tx_low", tx, 0);
        run_frames("t1", 40, 2, 500);
        check_val("t1_empty", empty, 1);

        // Parity even, then odd, at 1 clock per bit.
        scaler = 16'd0;
        par_en = 1'b1;
        par_odd = 1'b0;
        push_byte(8'h07);
        run_frames("t2_even", 11, 0, 200);
        par_odd = 1'b1;
        push_byte(8'h07);
        run_frames("t2_odd", 11, 0, 200);
        par_en = 1'b0;
        par_odd = 1'b0;

        // Fill past full while disabled, then drain back to back.
        en = 1'b0;
        for (int i = 0; i < 17; i++) begin
            @(posedge clk);
            #1;
            check_val("wready_fill", wready, (i < 16));
            wdata = 8'h10 + 8'(i);
            wvalid = 1'b1;
            if (i < 16) sb.push_back(wdata);
        end
        @(posedge clk);
        #1 wvalid = 1'b0;
        check_val("full_cnt", fifo_cnt, 16);
        check_val("full_wready", wready, 0);
        b2b_check = 1'b1;
        b2b_seen = 1'b0;
        en = 1'b1;
        run_frames("t3", 160, 0, 1000);
        b2b_check = 1'b0;
        check_val("t3_cnt", fifo_cnt, 0);

        // Two stop bits, 2 clocks per bit.
        en = 1'b0;
        scaler = 16'd1;
        stop2 = 1'b1;
        push_byte(8'hA3);
        push_byte(8'h3C);
        b2b_check = 1'b1;
        b2b_seen = 1'b0;
        en = 1'b1;
        run_frames("t4", 44, 0, 500);
        b2b_check = 1'b0;
        stop2 = 1'b0;

        // Asynchronous reset in the middle of the data bits.
        en = 1'b0;
        scaler = 16'd3;
        push_byte(8'h00);
        push_byte(8'h22);
        push_byte(8'h33);
        push_byte(8'h44);
        push_byte(8'h55);
        check_val("pre_rst_cnt", fifo_cnt, 5);
        en = 1'b1;
        w = 0;
        do begin
            @(posedge clk);
            #1;
            w++;
        end while (!busy && w < 50);
        check_val("t5_started", busy, 1);
        repeat (8) @(posedge clk);
        #1;
        check_val("pre_rst_tx", tx, 0);
        #1 rst_n = 1'b0;
        #1;
        check_val("arst_tx", tx, 1);
        check_val("arst_cnt", fifo_cnt, 0);
        check_val("arst_busy", busy, 0);
        check_val("arst_empty", empty, 1);
        check_val("arst_wready", wready, 1);
        sb.delete();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (60) @(posedge clk);
        #1;
        check_val("post_rst_busy", busy, 0);
        check_val("post_rst_tx", tx, 1);
        check_val("post_rst_cnt", fifo_cnt, 0);
        scaler = 16'd0;
        push_byte(8'hC6);
        run_frames("t5_after", 10, 0, 200);

        // Config changed mid-frame only affects the following frame.
        en = 1'b0;
        scaler = 16'd2;
        par_en = 1'b0;
        push_byte(8'h96);
        push_byte(8'h5A);
        b2b_check = 1'b1;
        b2b_seen = 1'b0;
        en = 1'b1;
        w = 0;
        do begin
            @(posedge clk);
            #1;
            w++;
        end while (!busy && w < 50);
        check_val("t6_started", busy, 1);
        pre = 1;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (busy) pre++;
        end
        scaler = 16'd0;
        par_en = 1'b1;
        run_frames("t6", 41, pre, 500);
        b2b_check = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
